// File: rtl/blit_scheduler_if.sv
// blit_scheduler_if: CPU command handshake plus blitter operand/handshake bundle.
interface blit_scheduler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [11:0] cmd_src;
    logic [3:0]  cmd_height;
    logic [6:0]  cmd_x;
    logic [5:0]  cmd_y;
    logic [2:0]  blit_op;
    logic [11:0] blit_src;
    logic [3:0]  blit_srcHeight;
    logic [6:0]  blit_destX;
    logic [5:0]  blit_destY;
    logic        blit_enable;
    logic        blit_ready;
    logic        blit_collision;
    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_height, cmd_x, cmd_y, blit_ready, blit_collision,
        output cmd_ready, blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY, blit_enable
    );
    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_height, cmd_x, cmd_y, blit_ready, blit_collision,
        input  cmd_ready, blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY, blit_enable
    );
endinterface

// File: rtl/blit_scheduler.sv
// blit_scheduler: blit command FIFO and one-at-a-time issue sequencer with vblank gating,
// busy timeout and sticky collision flag.
module blit_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vblank,
    input  logic                     gate_vblank,
    input  logic                     coll_clear,
    blit_scheduler_if.slave          bus,
    output logic                     busy,
    output logic                     done,
    output logic                     collision,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t state, state_nxt;
    logic [31:0] mem [DEPTH];
    logic [AW:0] wr, rd, wr_nxt, rd_nxt;
    logic [CW-1:0] cnt;
    logic push, pop, retire, empty;
    assign push            = bus.cmd_valid && bus.cmd_ready;
    assign empty           = wr == rd;
    assign wr_nxt          = wr + (AW + 1)'(push);
    assign rd_nxt          = rd + (AW + 1)'(pop);
    assign pending         = wr - rd;
    assign busy            = !empty || state != IDLE;
    assign bus.blit_enable = state == ISSUE;
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: if (!empty && bus.blit_ready && (!gate_vblank || vblank)) begin
                state_nxt = ISSUE;
                pop       = 1'b1;
            end
            ISSUE: state_nxt = WAIT_BUSY;
            // A blitter that never reports busy is assumed to have finished instantly.
            WAIT_BUSY: if (!bus.blit_ready) state_nxt = WAIT_DONE;
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    retire    = 1'b1;
                end
            default: if (bus.blit_ready) begin
                state_nxt = IDLE;
                retire    = 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk)
        if (push) mem[wr[AW-1:0]] <= {bus.cmd_op, bus.cmd_src, bus.cmd_height, bus.cmd_x, bus.cmd_y};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            wr             <= '0;
            rd             <= '0;
            cnt            <= '0;
            bus.cmd_ready  <= 1'b1;
            done           <= 1'b0;
            collision      <= 1'b0;
            {bus.blit_op, bus.blit_src, bus.blit_srcHeight, bus.blit_destX, bus.blit_destY} <= '0;
        end else begin
            state          <= state_nxt;
            wr             <= wr_nxt;
            rd             <= rd_nxt;
            cnt            <= state == WAIT_BUSY ? cnt + 1'b1 : '0;
            // Registered from the post-update pointers so a full FIFO never sees a push.
            bus.cmd_ready  <= (wr_nxt ^ rd_nxt) != (AW + 1)'(DEPTH);
            done           <= retire;
            collision      <= (retire & bus.blit_collision) | (collision & !coll_clear);
            if (pop)
                {bus.blit_op, bus.blit_src, bus.blit_srcHeight, bus.blit_destX, bus.blit_destY} <= mem[rd[AW-1:0]];
        end
endmodule

// File: tb/tb_blit_scheduler.sv
// tb_blit_scheduler: directed table-driven bench for blit_scheduler with a small blitter model
// that drops ready for a programmable number of cycles after each enable.
module tb_blit_scheduler;
    logic clk = 0, rst_n = 0, vblank = 0, gate_vblank = 0, coll_clear = 0;
    logic busy, done, collision;
    logic [2:0] pending;
    blit_scheduler_if bus();
    blit_scheduler #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .vblank(vblank), .gate_vblank(gate_vblank),
        .coll_clear(coll_clear), .bus(bus), .busy(busy), .done(done),
        .collision(collision), .pending(pending)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] src;
        logic [3:0]  h;
        logic [6:0]  x;
        logic [5:0]  y;
        int          hold;
        logic        coll;
        int          exp_done;
        logic        exp_coll;
    } vec_t;

    // Blitter model: ready low for hold_len cycles after each enable (0 = never drops).
    int hold_len = 0, model_cnt = 0;
    logic hold_low = 0, coll_r = 0;
    logic coll_q[$];
    always @(negedge clk)
        if (bus.blit_enable) begin
            coll_r    = coll_q.size() > 0 ? coll_q.pop_front() : 1'b0;
            model_cnt = hold_len;
        end else if (model_cnt > 0) model_cnt--;
    assign bus.blit_ready     = !hold_low && model_cnt == 0;
    assign bus.blit_collision = coll_r;

    int total = 0, bad = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic step(int n = 1);
        repeat (n) @(negedge clk);
    endtask
    task automatic send(logic [31:0] w);
        bus.cmd_valid = 1'b1;
        {bus.cmd_op, bus.cmd_src, bus.cmd_height, bus.cmd_x, bus.cmd_y} = w;
        step();
        bus.cmd_valid = 1'b0;
    endtask
    task automatic wait_done(int start, int lim, output int n);
        n = start;
        while (done !== 1'b1 && n < lim) begin
            step();
            n++;
        end
    endtask
    function automatic logic [31:0] fields();
        return {bus.blit_op, bus.blit_src, bus.blit_srcHeight, bus.blit_destX, bus.blit_destY};
    endfunction

    initial begin
        vec_t tbl[5];
        logic [31:0] fill[5];
        logic [31:0] w;
        int n, ens, dns;
        tbl[0] = '{3'd1, 12'h200, 4'd5,  7'd10,  6'd3,  20, 1'b0, 22, 1'b0};
        tbl[1] = '{3'd3, 12'hABC, 4'd15, 7'd127, 6'd63, 2,  1'b0, 4,  1'b0};
        tbl[2] = '{3'd7, 12'hFFF, 4'd0,  7'd0,   6'd0,  5,  1'b1, 7,  1'b1};
        tbl[3] = '{3'd2, 12'h001, 4'd9,  7'd64,  6'd32, 3,  1'b0, 5,  1'b1};
        tbl[4] = '{3'd5, 12'h555, 4'd10, 7'd85,  6'd21, 4,  1'b0, 6,  1'b1};
        fill   = '{32'h2468_ACE1, 32'h1357_9BDF, 32'hFEDC_BA98, 32'h0123_4567, 32'hDEAD_BEEF};
        bus.cmd_valid = 1'b0;
        {bus.cmd_op, bus.cmd_src, bus.cmd_height, bus.cmd_x, bus.cmd_y} = '0;
        step(2);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_enable", bus.blit_enable, 0);
        chk("rst_fields", fields(), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_collision", collision, 0);
        chk("rst_pending", pending, 0);
        rst_n = 1'b1;
        step();

        // Single commands through the whole issue/retire path.
        for (int i = 0; i < 5; i++) begin
            hold_len = tbl[i].hold;
            coll_q.push_back(tbl[i].coll);
            w = {tbl[i].op, tbl[i].src, tbl[i].h, tbl[i].x, tbl[i].y};
            send(w);
            chk("pend_after_push", pending, 1);
            step();
            chk("enable_on", bus.blit_enable, 1);
            chk("fields", fields(), w);
            chk("pend_after_pop", pending, 0);
            step();
            chk("enable_off", bus.blit_enable, 0);
            wait_done(2, 60, n);
            chk("done_delay", n, tbl[i].exp_done);
            chk("coll_sticky", collision, tbl[i].exp_coll);
            step();
            chk("done_single", done, 0);
            chk("busy_idle", busy, 0);
            chk("fields_hold", fields(), w);
        end

        // Fill and overflow while the blitter reports busy.
        hold_low = 1'b1;
        hold_len = 3;
        for (int i = 0; i < 5; i++) begin
            send(fill[i]);
            chk("fill_cmd_ready", bus.cmd_ready, i < 3 ? 1 : 0);
        end
        chk("fill_pending", pending, 4);
        hold_low = 1'b0;
        ens = 0;
        dns = 0;
        repeat (150) begin
            step();
            if (bus.blit_enable) begin
                if (ens < 4) chk("fill_order", fields(), fill[ens]);
                ens++;
            end
            if (done) dns++;
        end
        chk("fill_enables", ens, 4);
        chk("fill_dones", dns, 4);
        chk("fill_empty", pending, 0);

        // Vblank gate.
        gate_vblank = 1'b1;
        send(32'h3C3C_3C3C);
        ens = 0;
        repeat (100) begin
            step();
            if (bus.blit_enable) ens++;
        end
        chk("gate_hold", ens, 0);
        chk("gate_pending", pending, 1);
        vblank = 1'b1;
        step();
        chk("gate_enable", bus.blit_enable, 1);
        vblank = 1'b0;
        wait_done(0, 40, n);
        chk("gate_retire", done, 1);
        step();
        gate_vblank = 1'b0;

        // Collision accumulation and clear priority.
        coll_clear = 1'b1;
        step();
        coll_clear = 1'b0;
        chk("coll_cleared", collision, 0);
        coll_q.push_back(1'b0);
        coll_q.push_back(1'b1);
        coll_q.push_back(1'b0);
        send(32'h1111_1111);
        send(32'h2222_2222);
        send(32'h3333_3333);
        for (int i = 0; i < 3; i++) begin
            wait_done(0, 40, n);
            chk("coll_seq_done", done, 1);
            chk("coll_seq", collision, i > 0);
            step();
        end
        coll_clear = 1'b1;
        step();
        coll_clear = 1'b0;
        coll_q.push_back(1'b1);
        send(32'h4444_4444);
        step(4);
        coll_clear = 1'b1;
        step();
        chk("clr_vs_cap_done", done, 1);
        chk("clr_vs_cap", collision, 1);
        coll_clear = 1'b0;
        step(2);
        coll_clear = 1'b1;
        step();
        coll_clear = 1'b0;
        chk("clr_alone", collision, 0);

        // Timeout: ready never drops.
        hold_len = 0;
        coll_q.push_back(1'b1);
        send(32'h5555_5555);
        step();
        chk("to_enable", bus.blit_enable, 1);
        wait_done(1, 40, n);
        chk("to_delay", n, 17);
        chk("to_coll", collision, 1);
        step();
        hold_len = 3;
        coll_q.push_back(1'b0);
        send(32'h6666_6666);
        step();
        chk("to_next_enable", bus.blit_enable, 1);
        wait_done(1, 40, n);
        chk("to_next_delay", n, 5);
        step();

        // Reset while waiting for the blitter with two commands queued.
        hold_len = 0;
        send(32'h7777_7777);
        send(32'h8888_8888);
        hold_low = 1'b1;
        send(32'h9999_9999);
        step(3);
        chk("pre_rst_pending", pending, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        chk("mid_rst_fields", fields(), 0);
        chk("mid_rst_enable", bus.blit_enable, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_collision", collision, 0);
        step(2);
        rst_n = 1'b1;
        send(32'hABCD_1234);
        ens = 0;
        repeat (20) begin
            step();
            if (bus.blit_enable) ens++;
        end
        chk("post_rst_wait", ens, 0);
        chk("post_rst_pending", pending, 1);
        hold_low = 1'b0;
        step();
        chk("post_rst_enable", bus.blit_enable, 1);
        chk("post_rst_fields", fields(), 32'hABCD_1234);
        wait_done(1, 40, n);
        chk("post_rst_done", done, 1);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
